div_result_display: RTL

DIV_RESULT_DISPLAY -- requirements
Module: div_result_display

---
 rtl/div_result_display.sv | 129 ++++++++++++
 1 files changed

// File: rtl/div_result_display.sv
// Latches a divider result on each rising edge of done_in and scans it onto a 4-digit active-low 7-segment display.
// Latency: capture is one edge after done_in rises, display follows one edge later. Backpressure: none, inputs are sampled only on capture.
module div_result_display #(
    parameter int QUOTIENT_WIDTH  = 8,
    parameter int REMAINDER_WIDTH = 8,
    parameter int CNT             = 2000000
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic [QUOTIENT_WIDTH-1:0]  quotient_in,
    input  logic [REMAINDER_WIDTH-1:0] remainder_in,
    input  logic                       done_in,
    input  logic                       div_zero_in,
    output logic [6:0]                 led_out,
    output logic [3:0]                 anode_act,
    output logic                       disp_valid
);

    localparam int             CW      = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CNT - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_digit;
    logic          r_done_d;
    logic [7:0]    r_quot;
    logic [7:0]    r_rem;
    logic          r_dz;
    logic          r_valid;
    logic [6:0]    r_led;
    logic [3:0]    r_anode;

    logic [7:0]    w_quot8;
    logic [7:0]    w_rem8;
    logic          w_capture;
    logic          w_wrap;
    logic [3:0]    w_nibble;
    logic [3:0]    w_anode;
    logic [6:0]    w_seg;
    logic [6:0]    w_led;
    logic [3:0]    w_anode_out;

    always_comb begin
        w_quot8                     = '0;
        w_rem8                      = '0;
        w_quot8[QUOTIENT_WIDTH-1:0] = quotient_in;
        w_rem8[REMAINDER_WIDTH-1:0] = remainder_in;
    end

    // Level-high done_in only triggers once; a new capture needs a sampled low first.
    assign w_capture = done_in & ~r_done_d;
    assign w_wrap    = (r_cnt == CNT_MAX);

    always_comb begin
        w_anode  = 4'b1110;
        w_nibble = r_rem[3:0];
        case (r_digit)
            2'd0: begin w_anode = 4'b1110; w_nibble = r_rem[3:0];  end
            2'd1: begin w_anode = 4'b1101; w_nibble = r_rem[7:4];  end
            2'd2: begin w_anode = 4'b1011; w_nibble = r_quot[3:0]; end
            2'd3: begin w_anode = 4'b0111; w_nibble = r_quot[7:4]; end
            default: begin w_anode = 4'b1110; w_nibble = r_rem[3:0]; end
        endcase
    end

    always_comb begin
        w_seg = 7'h7F;
        case (w_nibble)
            4'h0: w_seg = 7'h01;
            4'h1: w_seg = 7'h4F;
            4'h2: w_seg = 7'h12;
            4'h3: w_seg = 7'h06;
            4'h4: w_seg = 7'h4C;
            4'h5: w_seg = 7'h24;
            4'h6: w_seg = 7'h20;
            4'h7: w_seg = 7'h0F;
            4'h8: w_seg = 7'h00;
            4'h9: w_seg = 7'h04;
            4'hA: w_seg = 7'h08;
            4'hB: w_seg = 7'h60;
            4'hC: w_seg = 7'h31;
            4'hD: w_seg = 7'h42;
            4'hE: w_seg = 7'h30;
            4'hF: w_seg = 7'h38;
            default: w_seg = 7'h7F;
        endcase
    end

    always_comb begin
        w_led       = 7'h7F;
        w_anode_out = 4'hF;
        if (r_valid) begin
            w_anode_out = w_anode;
            w_led       = r_dz ? 7'h7E : w_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_cnt    <= '0;
            r_digit  <= 2'd0;
            r_done_d <= 1'b0;
            r_quot   <= 8'h00;
            r_rem    <= 8'h00;
            r_dz     <= 1'b0;
            r_valid  <= 1'b0;
            r_led    <= 7'h7F;
            r_anode  <= 4'hF;
        end else begin
            r_done_d <= done_in;
            r_cnt    <= w_wrap ? '0 : r_cnt + CW'(1);
            if (w_wrap) begin
                r_digit <= r_digit + 2'd1;
            end
            if (w_capture) begin
                r_quot  <= w_quot8;
                r_rem   <= w_rem8;
                r_dz    <= div_zero_in;
                r_valid <= 1'b1;
            end
            r_led   <= w_led;
            r_anode <= w_anode_out;
        end
    end

    assign led_out    = r_led;
    assign anode_act  = r_anode;
    assign disp_valid = r_valid;

endmodule
